// File: rtl/cache_read_ctrl_pkg.sv
// Shared definitions for the direct-mapped read cache controller:
// default geometry, line count and FSM state encoding.
package cache_read_ctrl_pkg;

  localparam int IDX_DEF = 6;
  localparam int TAG_DEF = 24;
  localparam int DW_DEF  = 32;
  localparam int OFS_W   = 2;

  typedef enum logic [2:0] {
    ST_FLUSH   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_COMPARE = 3'd2,
    ST_MISS    = 3'd3,
    ST_FILL    = 3'd4
  } state_e;

  function automatic int unsigned lines(input int unsigned idx_w);
    return 32'd1 << idx_w;
  endfunction

endpackage

// File: rtl/cache_read_ctrl_flush_seq.sv
// Invalidation sweep counter: walks every index once after start_i,
// one line per cycle; done_o flags the cycle writing the last index.
module cache_flush_seq #(
  parameter int IDX = 6
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           start_i,
  output logic [IDX-1:0] cnt_o,
  output logic           busy_o,
  output logic           done_o
);

  logic [IDX-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '1);

endmodule

// File: rtl/cache_read_ctrl.sv
// Sequencer for a direct-mapped read cache: lookup, miss refill, and all valid-RAM writes.
//   state   | meaning
//   FLUSH   | sweeping valid=0 over every index (after reset and on flush)
//   IDLE    | waiting for cpu_req; RAMs sample the request index on the accept edge
//   COMPARE | RAM outputs valid; decide hit or miss
//   MISS    | mem_req held until mem_ack
//   FILL    | write valid/tag/data for the line and return the refilled word
module cache_read_ctrl
  import cache_read_ctrl_pkg::*;
#(
  parameter int IDX = IDX_DEF,
  parameter int TAG = TAG_DEF,
  parameter int DW  = DW_DEF,
  localparam int AW = TAG + IDX + OFS_W
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           cpu_req_i,
  input  logic [AW-1:0]  cpu_addr_i,
  output logic           cpu_ready_o,
  output logic [DW-1:0]  cpu_rdata_o,
  input  logic           flush_i,
  output logic           flush_busy_o,
  output logic [IDX-1:0] ram_index_o,
  output logic           ram_do_write_o,
  output logic           ram_valid_in_o,
  input  logic           ram_valid_out_i,
  input  logic [TAG-1:0] tag_rd_i,
  output logic [TAG-1:0] tag_wr_o,
  input  logic [DW-1:0]  data_rd_i,
  output logic [DW-1:0]  data_wr_o,
  output logic           mem_req_o,
  output logic [AW-1:0]  mem_addr_o,
  input  logic           mem_ack_i,
  input  logic [DW-1:0]  mem_rdata_i
);

  state_e         state_q, state_d;
  logic           flush_pend_q, flush_pend_d;
  logic           cpu_ready_q, cpu_ready_d;
  logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic           flush_busy_q, flush_busy_d;
  logic           do_write_q, do_write_d;
  logic           valid_in_q, valid_in_d;
  logic [TAG-1:0] tag_wr_q, tag_wr_d;
  logic [DW-1:0]  data_wr_q, data_wr_d;
  logic           mem_req_q, mem_req_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;

  logic           sweep_start, sweep_busy, sweep_done;
  logic [IDX-1:0] sweep_cnt;
  logic [TAG-1:0] addr_tag;
  logic [IDX-1:0] addr_idx;
  logic           hit;
  logic           unused_ofs;

  assign addr_tag   = cpu_addr_i[AW-1:IDX+OFS_W];
  assign addr_idx   = cpu_addr_i[IDX+OFS_W-1:OFS_W];
  assign unused_ofs = ^cpu_addr_i[OFS_W-1:0];
  assign hit        = ram_valid_out_i && (tag_rd_i == addr_tag);

  cache_flush_seq #(.IDX(IDX)) u_flush_seq (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (sweep_start),
    .cnt_o   (sweep_cnt),
    .busy_o  (sweep_busy),
    .done_o  (sweep_done)
  );

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    flush_busy_d = flush_busy_q;
    do_write_d   = 1'b0;
    valid_in_d   = 1'b0;
    tag_wr_d     = tag_wr_q;
    data_wr_d    = data_wr_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    sweep_start  = 1'b0;

    // A flush arriving mid-transaction waits for the next IDLE.
    if (flush_i && (state_q inside {ST_COMPARE, ST_MISS, ST_FILL})) flush_pend_d = 1'b1;

    unique case (state_q)
      ST_FLUSH: begin
        flush_busy_d = 1'b1;
        flush_pend_d = 1'b0;
        if (!sweep_busy) begin
          sweep_start = 1'b1;
          do_write_d  = 1'b1;
        end else if (sweep_done) begin
          state_d      = ST_IDLE;
          flush_busy_d = 1'b0;
        end else begin
          do_write_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush_i || flush_pend_q) begin
          state_d      = ST_FLUSH;
          flush_pend_d = 1'b0;
          flush_busy_d = 1'b1;
          sweep_start  = 1'b1;
          do_write_d   = 1'b1;
        end else if (cpu_req_i && !cpu_ready_q) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (hit) begin
          cpu_rdata_d = data_rd_i;
          cpu_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = {addr_tag, addr_idx, {OFS_W{1'b0}}};
          state_d    = ST_MISS;
        end
      end
      ST_MISS: begin
        if (mem_ack_i) begin
          mem_req_d   = 1'b0;
          cpu_rdata_d = mem_rdata_i;
          data_wr_d   = mem_rdata_i;
          tag_wr_d    = addr_tag;
          do_write_d  = 1'b1;
          valid_in_d  = 1'b1;
          cpu_ready_d = 1'b1;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_FLUSH;
      flush_pend_q <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      flush_busy_q <= 1'b1;
      do_write_q   <= 1'b0;
      valid_in_q   <= 1'b0;
      tag_wr_q     <= '0;
      data_wr_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      flush_busy_q <= flush_busy_d;
      do_write_q   <= do_write_d;
      valid_in_q   <= valid_in_d;
      tag_wr_q     <= tag_wr_d;
      data_wr_q    <= data_wr_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign ram_index_o    = (state_q == ST_FLUSH) ? sweep_cnt : addr_idx;
  assign cpu_ready_o    = cpu_ready_q;
  assign cpu_rdata_o    = cpu_rdata_q;
  assign flush_busy_o   = flush_busy_q;
  assign ram_do_write_o = do_write_q;
  assign ram_valid_in_o = valid_in_q;
  assign tag_wr_o       = tag_wr_q;
  assign data_wr_o      = data_wr_q;
  assign mem_req_o      = mem_req_q;
  assign mem_addr_o     = mem_addr_q;

endmodule
